// File: rtl/matrix_scan_bcm_pkg.sv
// Shared types and width helpers for the HUB75 BCM scan controller.
package matrix_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_ON,
        ST_BLANK,
        ST_LATCH
    } scan_state_e;

    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned COL_W   = width_of(64);
    localparam int unsigned ROW_W   = width_of(16);
    localparam int unsigned PLANE_W = width_of(6);

    // Full (dim+1)*(base<<plane) product width, kept untruncated before the >>8.
    function automatic int unsigned on_width(input int unsigned bit_depth,
                                             input int unsigned base_ticks);
        return 8 + bit_depth + $clog2(base_ticks) + 1;
    endfunction

endpackage

// File: rtl/matrix_scan_bcm_if.sv
// Control inputs and panel/fetch outputs of the scan controller.
interface matrix_scan_bcm_if
    import matrix_scan_pkg::*;
#(
    parameter int unsigned COLUMNS   = 64,
    parameter int unsigned SCAN_ROWS = 16,
    parameter int unsigned BIT_DEPTH = 6
);
    localparam int unsigned CW = width_of(COLUMNS);
    localparam int unsigned RW = width_of(SCAN_ROWS);
    localparam int unsigned PW = width_of(BIT_DEPTH);

    logic          enable;
    logic [7:0]    global_dim;
    logic          swap_request;
    logic [CW-1:0] column_address;
    logic [RW-1:0] row_address;
    logic [PW-1:0] bit_index;
    logic [RW-1:0] row_address_active;
    logic          clk_pixel;
    logic          row_latch;
    logic          output_enable;
    logic          buffer_select;
    logic          swap_ack;
    logic          frame_start;

    modport master (
        input  enable, global_dim, swap_request,
        output column_address, row_address, bit_index, row_address_active,
               clk_pixel, row_latch, output_enable, buffer_select, swap_ack, frame_start
    );

    modport slave (
        output enable, global_dim, swap_request,
        input  column_address, row_address, bit_index, row_address_active,
               clk_pixel, row_latch, output_enable, buffer_select, swap_ack, frame_start
    );
endinterface

// File: rtl/matrix_scan_bcm_on_timer.sv
// BCM on-timer: loads the scaled plane on-time at latch and counts it down.
module bcm_on_timer
    import matrix_scan_pkg::*;
#(
    parameter int unsigned BIT_DEPTH     = 6,
    parameter int unsigned BASE_ON_TICKS = 8,
    parameter int unsigned PW            = 3
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          load_i,
    input  logic [PW-1:0] plane_i,
    input  logic [7:0]    dim_i,
    output logic          oe_o,
    output logic          busy_o
);
    localparam int unsigned W = on_width(BIT_DEPTH, BASE_ON_TICKS);

    logic [W-1:0] prod;
    logic [W-1:0] ticks;
    logic [W-1:0] cnt_q;

    always_comb begin
        prod  = (W'(dim_i) + W'(1)) * (W'(BASE_ON_TICKS) << plane_i);
        ticks = prod >> 8;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= ticks;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign oe_o   = (cnt_q != '0);
    // Still on after the coming edge: the scan must not blank yet.
    assign busy_o = (cnt_q > W'(1));

endmodule

// File: rtl/matrix_scan_bcm.sv
// HUB75 scan controller: column shift, BCM plane/row sequencing, latch and buffer swap.
module matrix_scan_bcm
    import matrix_scan_pkg::*;
#(
    parameter int unsigned COLUMNS       = 64,
    parameter int unsigned SCAN_ROWS     = 16,
    parameter int unsigned BIT_DEPTH     = 6,
    parameter int unsigned FETCH_LATENCY = 1,
    parameter int unsigned BASE_ON_TICKS = 8
) (
    input  logic               clk_in,
    input  logic               reset,
    matrix_scan_bcm_if.master  bus
);
    localparam int unsigned CW = width_of(COLUMNS);
    localparam int unsigned RW = width_of(SCAN_ROWS);
    localparam int unsigned PW = width_of(BIT_DEPTH);
    localparam int unsigned SW = width_of(FETCH_LATENCY + 2);

    localparam logic [CW-1:0] COL_LAST   = CW'(COLUMNS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(SCAN_ROWS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(BIT_DEPTH - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(FETCH_LATENCY + 1);
    localparam logic [SW-1:0] SLOT_PRE   = SW'(FETCH_LATENCY);

    scan_state_e   state_q;
    logic [SW-1:0] slot_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q, row_act_q, row_nx;
    logic [PW-1:0] plane_q, plane_nx;
    logic          clk_pix_q, latch_q, buf_q, ack_q, fstart_q;
    logic          frame_end, on_oe, on_busy;

    always_comb begin
        frame_end = (row_q == ROW_LAST) && (plane_q == PLANE_LAST);
        plane_nx  = plane_q + PW'(1);
        row_nx    = row_q;
        if (plane_q == PLANE_LAST) begin
            plane_nx = '0;
            row_nx   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            plane_q   <= '0;
            row_act_q <= '0;
            clk_pix_q <= 1'b0;
            latch_q   <= 1'b0;
            buf_q     <= 1'b0;
            ack_q     <= 1'b0;
            fstart_q  <= 1'b0;
        end else begin
            latch_q  <= 1'b0;
            ack_q    <= 1'b0;
            fstart_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_q   <= ST_SHIFT;
                        slot_q    <= '0;
                        col_q     <= '0;
                        clk_pix_q <= 1'b0;
                        fstart_q  <= (row_q == '0) && (plane_q == '0);
                    end
                end
                ST_SHIFT: begin
                    if (slot_q == SLOT_LAST) begin
                        slot_q    <= '0;
                        clk_pix_q <= 1'b0;
                        if (col_q == COL_LAST) begin
                            col_q   <= '0;
                            state_q <= on_busy ? ST_WAIT_ON : ST_BLANK;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end else begin
                        slot_q    <= slot_q + SW'(1);
                        clk_pix_q <= (slot_q == SLOT_PRE);
                    end
                end
                ST_WAIT_ON: begin
                    if (!on_busy) state_q <= ST_BLANK;
                end
                ST_BLANK: begin
                    state_q <= ST_LATCH;
                    latch_q <= 1'b1;
                    // Swap is decided on entry so ack and the new buffer line up with the wrap latch.
                    if (frame_end && bus.swap_request) begin
                        ack_q <= 1'b1;
                        buf_q <= ~buf_q;
                    end
                end
                ST_LATCH: begin
                    row_act_q <= row_q;
                    plane_q   <= plane_nx;
                    row_q     <= row_nx;
                    if (bus.enable) begin
                        state_q   <= ST_SHIFT;
                        slot_q    <= '0;
                        col_q     <= '0;
                        clk_pix_q <= 1'b0;
                        fstart_q  <= (row_nx == '0) && (plane_nx == '0);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    bcm_on_timer #(
        .BIT_DEPTH    (BIT_DEPTH),
        .BASE_ON_TICKS(BASE_ON_TICKS),
        .PW           (PW)
    ) u_on_timer (
        .clk_in (clk_in),
        .reset  (reset),
        .load_i (state_q == ST_LATCH),
        .plane_i(plane_q),
        .dim_i  (bus.global_dim),
        .oe_o   (on_oe),
        .busy_o (on_busy)
    );

    assign bus.column_address     = col_q;
    assign bus.row_address        = row_q;
    assign bus.bit_index          = plane_q;
    assign bus.row_address_active = row_act_q;
    assign bus.clk_pixel          = clk_pix_q;
    assign bus.row_latch          = latch_q;
    assign bus.output_enable      = on_oe;
    assign bus.buffer_select      = buf_q;
    assign bus.swap_ack           = ack_q;
    assign bus.frame_start        = fstart_q;

endmodule

// File: doc/matrix_scan_bcm.md
Name: matrix_scan_bcm

Overview:
Parametrised HUB75 scan controller for LED panels of any column count, scan-row count and colour bit depth. Drives binary-coded-modulation (BCM) plane sequencing with programmable global dimming. Provides a frame-boundary framebuffer swap handshake. Sits between the framebuffer fetch logic (consumes column/row/plane addresses) and the panel pins (pixel clock, latch, OE, row select).

Parameters:
COLUMNS, 64, pixels shifted per plane load; must be ≥2
SCAN_ROWS, 16, row-select count (panel height / 2)
BIT_DEPTH, 6, BCM planes per row
FETCH_LATENCY, 1, clocks from column_address change until RGB data is valid at the pins
BASE_ON_TICKS, 8, plane-0 OE on-time in clocks at full brightness

Ports:
clk_in  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  run scanning; when low, finish current plane, then idle
global_dim  input  8  brightness scale, 0 = dark, 255 = full
swap_request  input  1  level; request framebuffer swap at next frame end
column_address  output  $clog2(COLUMNS)  column being fetched/shifted
row_address  output  $clog2(SCAN_ROWS)  row being loaded
bit_index  output  $clog2(BIT_DEPTH)  plane being loaded
row_address_active  output  $clog2(SCAN_ROWS)  row select to panel (A..D..)
clk_pixel  output  1  panel shift clock
row_latch  output  1  panel latch strobe
output_enable  output  1  active-high display enable (inverted at pin)
buffer_select  output  1  framebuffer half being read
swap_ack  output  1  one-cycle pulse when swap is taken
frame_start  output  1  one-cycle pulse at row 0 / plane 0 shift start

Behaviour:
- Reset: all outputs 0; state IDLE; on-timer cleared. Reset mid-operation returns to these values on the next edge, no partial latch.
- States: IDLE, SHIFT, WAIT_ON, BLANK, LATCH.
- IDLE -> SHIFT when enable=1. frame_start pulses on entry if row=0 and plane=0.
- SHIFT: COLUMNS slots of FETCH_LATENCY+2 clocks each.
  - column_address is set at slot cycle 0.
  - clk_pixel=0 for cycles 0..FETCH_LATENCY; clk_pixel=1 on the final cycle.
  - Column 0..COLUMNS-1, no gaps. Plane load = COLUMNS*(FETCH_LATENCY+2) clocks.
- After the last slot:
  - If the on-timer is still running -> WAIT_ON: OE stays as-is until the timer expires.
  - Otherwise -> BLANK.
- BLANK: exactly 1 clock, OE=0.
- LATCH: 1 clock.
  - row_latch=1, OE=0.
  - On this edge: row_address_active <= row_address.
  - On-timer loads on_ticks = ((global_dim+1)*(BASE_ON_TICKS<<bit_index))>>8, with global_dim sampled at this edge.
  - Plane/row counters advance: plane first, then row.
  - Next state: SHIFT if enable=1, else IDLE.
- ON period: OE=1 from the cycle after LATCH for on_ticks clocks; it runs concurrently with the next SHIFT. on_ticks=0 means OE is never asserted for that plane.
- Product width: 8+BIT_DEPTH+$clog2(BASE_ON_TICKS)+1 bits, no truncation before the shift.
- Wrap: the plane wraps BIT_DEPTH-1 -> 0 with row+1; the row wraps SCAN_ROWS-1 -> 0 (this is frame end).
- Frame end (in that LATCH cycle):
  - If swap_request=1: swap_ack=1 for 1 clock and buffer_select toggles.
  - The request is ignored at any other time.
- enable dropped mid-plane: current SHIFT/LATCH completes; the ON period completes; the controller rests in IDLE with OE=0; counters are retained.
- The controller never asserts OE and row_latch in the same cycle.

Decomposition:
- Package matrix_scan_pkg holds:
  - the state enum;
  - width helper constants (COL_W, ROW_W, PLANE_W);
  - on-time width function.
- Sub-module bcm_on_timer: computes on_ticks from plane and dim, counts down, and outputs running/OE.

Test Plan:
All tests use COLUMNS=4, SCAN_ROWS=2, BIT_DEPTH=2, FETCH_LATENCY=1, BASE_ON_TICKS=8.
- Reset then enable=1, dim=255 -> frame_start at the first SHIFT cycle; 4 slots of 3 clocks, clk_pixel high on cycles 2,5,8,11; column_address 0,1,2,3; BLANK then row_latch at cycle 13.
- dim=255 -> OE high 8 clocks after the plane-0 latch and 16 clocks after the plane-1 latch. The plane-1 SHIFT (12 clk) finishes before the 16-clk ON period, so the controller enters WAIT_ON for 4 clocks, then BLANK, then LATCH.
- dim=127 -> on_ticks 4 and 8; dim=0 -> OE never high for a full frame while latches continue.
- swap_request held high -> exactly one swap_ack per frame, coincident with the LATCH where row 1 / plane 1 wraps; buffer_select toggles there and is constant otherwise.
- enable dropped at column 2 of a SHIFT -> that load completes and latches, OE runs its on_ticks, then IDLE with OE=0; re-enable resumes at the next plane without a frame_start.
- reset asserted during WAIT_ON -> next clock all outputs 0; after release, the first latched row is row 0, plane 0.
